multi_strip_led_driver: RTL

//  Next-generation LED strip output stage for the linear visualizer path. Snapshots per-bin colours and
//  per-bin LED counts from LinearVisualizer, expands them into per-LED pixels, and serialises APA102-style

---
 rtl/multi_strip_led_driver_pkg.sv | 22 ++
 rtl/multi_strip_led_driver_bit_timer.sv | 35 +++
 rtl/multi_strip_led_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/multi_strip_led_driver_pkg.sv
// Shared types and constants for the multi-strip APA102-style LED output stage.
package multi_strip_led_driver_pkg;

    typedef logic [23:0] rgb_t;

    localparam int APA_START_BITS = 32;
    localparam logic [2:0] APA_HDR = 3'b111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START_FR = 3'd1,
        LED_FR   = 3'd2,
        END_FR   = 3'd3,
        DONE     = 3'd4
    } led_fsm_t;

    // rgb_t is {R,G,B}; the wire order is header, brightness, B, G, R
    function automatic logic [31:0] apa_word(input logic [4:0] bri, input rgb_t pix);
        return {APA_HDR, bri, pix[7:0], pix[15:8], pix[23:16]};
    endfunction

endpackage

// File: rtl/multi_strip_led_driver_bit_timer.sv
// Serial bit timer: FREQ_DIV cycles low, FREQ_DIV cycles high, with a strobe ahead of each low phase.
module led_bit_timer #(
    parameter int FREQ_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clk_out,
    output logic low_start
);

    localparam int PW = (2 * FREQ_DIV > 1) ? $clog2(2 * FREQ_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(2 * FREQ_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(FREQ_DIV);

    logic [PW-1:0] cnt_r;

    // Phase counter; clk_out goes high once the counter has spent FREQ_DIV cycles in the low half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            clk_out <= 1'b0;
        end else if (en) begin
            cnt_r   <= (cnt_r == LAST) ? '0 : cnt_r + 1'b1;
            clk_out <= (cnt_r >= HALF);
        end else begin
            cnt_r   <= '0;
            clk_out <= 1'b0;
        end
    end

    // Also marks the end of the previous bit, since bits are back to back
    assign low_start = en && (cnt_r == '0);

endmodule

// File: rtl/multi_strip_led_driver.sv
// Snapshots per-bin colours/counts, expands them to per-LED pixels and streams APA102 frames on CHANNELS strips.
module multi_strip_led_driver
    import multi_strip_led_driver_pkg::*;
#(
    parameter int LEDS     = 50,
    parameter int BIN_QTY  = 12,
    parameter int CHANNELS = 2,
    parameter int FREQ     = 12_000_000,
    parameter int FREQ_DIV = 5,
    parameter int END_BITS = 32,
    localparam int CW      = $clog2(LEDS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  rgb_t [BIN_QTY-1:0]               rgb,
    input  logic [BIN_QTY-1:0][CW-1:0]       LEDCounts,
    input  logic [4:0]                       brightness,
    input  logic [CHANNELS-1:0]              reverse,
    output logic [CHANNELS-1:0]              dOut,
    output logic                             clkOut,
    output logic                             busy,
    output logic                             done
);

    localparam int SW = CW + $clog2(BIN_QTY) + 1;
    localparam int EW = $clog2(END_BITS + 1);

    if (FREQ < 1 || FREQ_DIV < 1 || END_BITS < (LEDS + 1) / 2 || END_BITS % 8 != 0) begin : g_bad_params
        $error("multi_strip_led_driver: illegal parameter combination");
    end

    led_fsm_t                         state_r, state_s;
    logic [4:0]                       bit_cnt_r;
    logic [CW-1:0]                    led_cnt_r;
    logic [EW-1:0]                    end_cnt_r;
    rgb_t [BIN_QTY-1:0]               rgb_r;
    logic [BIN_QTY-1:0][SW-1:0]       psum_s, psum_r;
    logic [4:0]                       bri_r;
    logic [CHANNELS-1:0]              rev_r;
    rgb_t [CHANNELS-1:0]              pix_s, pix_r;
    logic [CHANNELS-1:0][31:0]        word_r;
    logic [SW-1:0]                    acc_s, j_s;
    logic [CW-1:0]                    look_idx_s;
    logic                             accept_s, timer_en_s, low_start_s;

    assign accept_s   = start && (state_r == IDLE || state_r == DONE);
    assign timer_en_s = (state_r == START_FR) || (state_r == LED_FR) || (state_r == END_FR);
    assign look_idx_s = (state_r == LED_FR) ? led_cnt_r + 1'b1 : '0;

    led_bit_timer #(.FREQ_DIV(FREQ_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (timer_en_s),
        .clk_out   (clkOut),
        .low_start (low_start_s)
    );

    // Prefix sums of the live counts, latched together with the snapshot
    always_comb begin
        acc_s  = '0;
        psum_s = '0;
        for (int k = 0; k < BIN_QTY; k++) begin
            acc_s     = acc_s + SW'(LEDCounts[k]);
            psum_s[k] = acc_s;
        end
    end

    // Pixel of the next LED per channel: lowest bin whose prefix sum exceeds the logical index
    always_comb begin
        pix_s = '0;
        j_s   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            j_s = rev_r[c] ? SW'(LEDS - 1) - SW'(look_idx_s) : SW'(look_idx_s);
            for (int k = BIN_QTY - 1; k >= 0; k--) begin
                pix_s[c] = (j_s < psum_r[k]) ? rgb_r[k] : pix_s[c];
            end
        end
    end

    // Frame sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     state_s = accept_s ? START_FR : IDLE;
            START_FR: state_s = (low_start_s && bit_cnt_r == 5'(APA_START_BITS - 1)) ? LED_FR : START_FR;
            LED_FR:   state_s = (low_start_s && bit_cnt_r == 5'd31 && led_cnt_r == CW'(LEDS - 1)) ? END_FR : LED_FR;
            END_FR:   state_s = (low_start_s && end_cnt_r == EW'(END_BITS)) ? DONE : END_FR;
            DONE:     state_s = accept_s ? START_FR : IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // Snapshot capture, bit/LED counters and per-channel serialisers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dOut      <= '0;
            bit_cnt_r <= '0;
            led_cnt_r <= '0;
            end_cnt_r <= '0;
            rgb_r     <= '0;
            psum_r    <= '0;
            bri_r     <= '0;
            rev_r     <= '0;
            pix_r     <= '0;
            word_r    <= '0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == START_FR) || (state_s == LED_FR) || (state_s == END_FR);
            done    <= (state_s == DONE);
            pix_r   <= pix_s;
            if (accept_s) begin
                rgb_r     <= rgb;
                psum_r    <= psum_s;
                bri_r     <= brightness;
                rev_r     <= reverse;
                bit_cnt_r <= '0;
                led_cnt_r <= '0;
                end_cnt_r <= '0;
                dOut      <= '0;
            end else if (low_start_s) begin
                case (state_r)
                    START_FR: begin
                        dOut      <= '0;
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            word_r[c] <= apa_word(bri_r, pix_r[c]);
                        end
                    end
                    LED_FR: begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            dOut[c]   <= word_r[c][31];
                            word_r[c] <= (bit_cnt_r == 5'd31) ? apa_word(bri_r, pix_r[c])
                                                              : {word_r[c][30:0], 1'b0};
                        end
                        if (bit_cnt_r == 5'd31) begin
                            led_cnt_r <= led_cnt_r + 1'b1;
                        end
                    end
                    END_FR: begin
                        if (end_cnt_r == EW'(END_BITS)) begin
                            dOut <= '0;
                        end else begin
                            dOut      <= '1;
                            end_cnt_r <= end_cnt_r + 1'b1;
                        end
                    end
                    default: dOut <= dOut;
                endcase
            end
        end
    end

endmodule
